// File: rtl/flip_engine.sv
// flip_engine: move-update responder; walks the 8 directions one cell per clock and flips bracketed discs.
// Build macro FLIP_ENGINE_PROBE_EN adds i_probe: count legal flips without modifying the board.
module flip_engine #(
  parameter logic [1:0] EMPTY = 2'd2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_color,
  input  logic [2:0]   i_row,
  input  logic [2:0]   i_col,
`ifdef FLIP_ENGINE_PROBE_EN
  input  logic         i_probe,
`endif
  input  logic [127:0] i_board,
  output logic [127:0] o_board,
  output logic [4:0]   o_flip,
  output logic         o_done,
  output logic         o_busy
);

  localparam int unsigned BOARD_W = 128;
  localparam int unsigned CRD_W   = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TOT_W   = 5;
  localparam int unsigned DIR_W   = 3;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned LAST_DIR = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SCAN  = 3'd2,
    S_FLIP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BOARD_W-1:0]  work_q, work_d;
  logic [BOARD_W-1:0]  board_q, board_d;
  logic                color_q, color_d;
  logic [2:0]          row_q, row_d;
  logic [2:0]          col_q, col_d;
  logic [DIR_W-1:0]    dir_q, dir_d;
  logic [CRD_W-1:0]    cur_r_q, cur_r_d;
  logic [CRD_W-1:0]    cur_c_q, cur_c_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TOT_W-1:0]    total_q, total_d;
  logic [TOT_W-1:0]    flip_q, flip_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                accept_c;
  logic                probe_c;
  logic                next_dir_c;
  logic [CRD_W-1:0]    tgt_r_c, tgt_c_c;
  logic [CRD_W-1:0]    dr_c, dc_c;
  logic [CRD_W-1:0]    ndr_c, ndc_c;
  logic [CRD_W-1:0]    d0r_c, d0c_c;
  logic [CRD_W-1:0]    back_r_c, back_c_c;
  logic [IDX_W-1:0]    scan_idx_c, back_idx_c, tgt_idx_c;
  logic [1:0]          cell_c, tgt_cell_c;
  logic                off_c;

  // Signed 4-bit row/col step for each direction, packed {dr, dc}.
  function automatic logic [2*CRD_W-1:0] dir_delta(input logic [DIR_W-1:0] dir);
    logic [2*CRD_W-1:0] d;
    case (dir)
      3'd0:    d = {4'hF, 4'h0};
      3'd1:    d = {4'hF, 4'h1};
      3'd2:    d = {4'h0, 4'h1};
      3'd3:    d = {4'h1, 4'h1};
      3'd4:    d = {4'h1, 4'h0};
      3'd5:    d = {4'h1, 4'hF};
      3'd6:    d = {4'h0, 4'hF};
      default: d = {4'hF, 4'hF};
    endcase
    return d;
  endfunction

  assign accept_c = (state_q == S_IDLE) && i_start && !busy_q;

`ifdef FLIP_ENGINE_PROBE_EN
  logic probe_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      probe_q <= 1'b0;
    else if (accept_c) probe_q <= i_probe;
  end
  assign probe_c = probe_q;
`else
  assign probe_c = 1'b0;
`endif

  assign tgt_r_c            = {1'b0, row_q};
  assign tgt_c_c            = {1'b0, col_q};
  assign {dr_c, dc_c}       = dir_delta(dir_q);
  assign {ndr_c, ndc_c}     = dir_delta(dir_q + DIR_W'(1));
  assign {d0r_c, d0c_c}     = dir_delta(DIR_W'(0));
  assign back_r_c           = cur_r_q - dr_c;
  assign back_c_c           = cur_c_q - dc_c;
  // Coordinates leave 0..7 exactly when the 4-bit sign bit is set (-1 or 8).
  assign off_c              = cur_r_q[CRD_W-1] | cur_c_q[CRD_W-1];
  assign scan_idx_c         = {cur_r_q[2:0], cur_c_q[2:0], 1'b0};
  assign back_idx_c         = {back_r_c[2:0], back_c_c[2:0], 1'b0};
  assign tgt_idx_c          = {row_q, col_q, 1'b0};
  assign cell_c             = work_q[scan_idx_c +: 2];
  assign tgt_cell_c         = work_q[tgt_idx_c +: 2];

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    board_d    = board_q;
    color_d    = color_q;
    row_d      = row_q;
    col_d      = col_q;
    dir_d      = dir_q;
    cur_r_d    = cur_r_q;
    cur_c_d    = cur_c_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    flip_d     = flip_q;
    done_d     = 1'b0;
    busy_d     = busy_q & ~done_q;
    next_dir_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          work_d  = i_board;
          color_d = i_color;
          row_d   = i_row;
          col_d   = i_col;
          total_d = '0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!tgt_cell_c[1]) begin
          state_d = S_DONE;
        end else begin
          dir_d   = '0;
          cur_r_d = tgt_r_c + d0r_c;
          cur_c_d = tgt_c_c + d0c_c;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (off_c || cell_c[1]) begin
          next_dir_c = 1'b1;
        end else if (cell_c[0] != color_q) begin
          cnt_d   = cnt_q + CNT_W'(1);
          cur_r_d = cur_r_q + dr_c;
          cur_c_d = cur_c_q + dc_c;
        end else if (cnt_q == '0) begin
          next_dir_c = 1'b1;
        end else begin
          state_d = S_FLIP;
        end
      end
      S_FLIP: begin
        if ((back_r_c == tgt_r_c) && (back_c_c == tgt_c_c)) begin
          next_dir_c = 1'b1;
        end else begin
          cur_r_d = back_r_c;
          cur_c_d = back_c_c;
          total_d = total_q + TOT_W'(1);
          if (!probe_c) work_d[back_idx_c +: 2] = {1'b0, color_q};
        end
      end
      S_DONE: begin
        if ((total_q != '0) && !probe_c) work_d[tgt_idx_c +: 2] = {1'b0, color_q};
        board_d = work_d;
        flip_d  = total_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Advance to the next direction, or finish after NW.
    if (next_dir_c) begin
      if (dir_q == DIR_W'(LAST_DIR)) begin
        state_d = S_DONE;
      end else begin
        dir_d   = dir_q + DIR_W'(1);
        cur_r_d = tgt_r_c + ndr_c;
        cur_c_d = tgt_c_c + ndc_c;
        cnt_d   = '0;
        state_d = S_SCAN;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      work_q  <= {64{EMPTY}};
      board_q <= {64{EMPTY}};
      color_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= '0;
      cur_r_q <= '0;
      cur_c_q <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      flip_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      board_q <= board_d;
      color_q <= color_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      cur_r_q <= cur_r_d;
      cur_c_q <= cur_c_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      flip_q  <= flip_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_board = board_q;
  assign o_flip  = flip_q;
  assign o_done  = done_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_flip_engine.sv
// Directed bench for flip_engine: vector table plus hand sequences for busy-start, reset abort and probe.
module tb_flip_engine;

  localparam logic [127:0] EMPTY_B = {64{2'b10}};

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic         i_color;
  logic [2:0]   i_row;
  logic [2:0]   i_col;
  logic [127:0] i_board;
  logic [127:0] o_board;
  logic [4:0]   o_flip;
  logic         o_done;
  logic         o_busy;
`ifdef FLIP_ENGINE_PROBE_EN
  logic         i_probe;
`endif

  flip_engine dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_color (i_color),
    .i_row   (i_row),
    .i_col   (i_col),
`ifdef FLIP_ENGINE_PROBE_EN
    .i_probe (i_probe),
`endif
    .i_board (i_board),
    .o_board (o_board),
    .o_flip  (o_flip),
    .o_done  (o_done),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [127:0] board;
    logic         color;
    logic [2:0]   row;
    logic [2:0]   col;
    logic [127:0] exp_board;
    logic [4:0]   exp_flip;
    int           exp_lat;
  } vec_t;

  vec_t         vecs [8];
  int           n_chk;
  int           n_pass;
  int           lat;
  logic         busy_ok;
  logic         saw_done;
  logic [127:0] open_b, multi_b, line_b, edge_b, wrap_b, tmp_b;

  function automatic logic [127:0] put(input logic [127:0] b, input int r, input int c,
                                       input logic [1:0] v);
    logic [127:0] t;
    t = b;
    t[2*(8*r+c) +: 2] = v;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One move: start at a negedge, scramble inputs after accept, wait (bounded) for o_done.
  task automatic run_move(input logic [127:0] b, input logic c, input logic [2:0] r,
                          input logic [2:0] cl, input int pulse_at);
    @(posedge i_clk);
    @(negedge i_clk);
    i_board = b; i_color = c; i_row = r; i_col = cl; i_start = 1'b1;
    lat = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge i_clk);
      #1;
      if (n == 1) begin
        i_start = 1'b0; i_board = ~b; i_row = ~r; i_col = ~cl; i_color = ~c;
      end
      if (pulse_at != 0 && n == pulse_at) i_start = 1'b1;
      if (pulse_at != 0 && n == pulse_at + 1) i_start = 1'b0;
      busy_ok = busy_ok & o_busy;
      if (o_done) begin
        lat = n;
        break;
      end
    end
    i_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    i_rst_n = 1'b0; i_start = 1'b0; i_color = 1'b0; i_row = '0; i_col = '0; i_board = EMPTY_B;
`ifdef FLIP_ENGINE_PROBE_EN
    i_probe = 1'b0;
`endif

    open_b = put(put(put(put(EMPTY_B, 3, 3, 2'd0), 4, 4, 2'd0), 3, 4, 2'd1), 4, 3, 2'd1);
    wrap_b = put(put(EMPTY_B, 1, 0, 2'd1), 1, 1, 2'd0);
    multi_b = put(put(put(EMPTY_B, 3, 2, 2'd1), 2, 3, 2'd1), 4, 3, 2'd1);
    multi_b = put(put(put(multi_b, 3, 1, 2'd0), 1, 3, 2'd0), 5, 3, 2'd0);
    line_b = put(EMPTY_B, 0, 7, 2'd1);
    for (int c = 1; c <= 6; c++) line_b = put(line_b, 0, c, 2'd0);
    edge_b = EMPTY_B;
    for (int c = 0; c <= 6; c++) edge_b = put(edge_b, 7, c, 2'd0);

    vecs[0] = '{open_b, 1'b0, 3'd2, 3'd4, put(put(open_b, 2, 4, 2'd0), 3, 4, 2'd0), 5'd1, 0};
    vecs[1] = '{open_b, 1'b0, 3'd0, 3'd0, open_b, 5'd0, 0};
    vecs[2] = '{open_b, 1'b1, 3'd3, 3'd3, open_b, 5'd0, 3};
    vecs[3] = '{wrap_b, 1'b0, 3'd0, 3'd7, wrap_b, 5'd0, 0};
    tmp_b = put(put(put(put(multi_b, 3, 3, 2'd0), 3, 2, 2'd0), 2, 3, 2'd0), 4, 3, 2'd0);
    vecs[4] = '{multi_b, 1'b0, 3'd3, 3'd3, tmp_b, 5'd3, 0};
    tmp_b = EMPTY_B;
    for (int c = 0; c <= 7; c++) tmp_b = put(tmp_b, 0, c, 2'd1);
    vecs[5] = '{line_b, 1'b1, 3'd0, 3'd0, tmp_b, 5'd6, 0};
    vecs[6] = '{edge_b, 1'b1, 3'd7, 3'd7, edge_b, 5'd0, 0};
    vecs[7] = '{open_b, 1'b1, 3'd2, 3'd3, put(put(open_b, 2, 3, 2'd1), 3, 3, 2'd1), 5'd1, 0};

    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_board", o_board, EMPTY_B);
    chk("reset_flip", 128'(o_flip), 128'd0);
    chk("reset_done", 128'(o_done), 128'd0);
    chk("reset_busy", 128'(o_busy), 128'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_move(vecs[i].board, vecs[i].color, vecs[i].row, vecs[i].col, 0);
      chk($sformatf("v%0d_flip", i), 128'(o_flip), 128'(vecs[i].exp_flip));
      chk($sformatf("v%0d_board", i), o_board, vecs[i].exp_board);
      if (vecs[i].exp_lat != 0)
        chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
      else
        chk($sformatf("v%0d_latency_bound", i), 128'(lat >= 1 && lat <= 128), 128'd1);
      chk($sformatf("v%0d_busy_held", i), 128'(busy_ok), 128'd1);
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 128'({o_done, o_busy}), 128'd0);
    end

    // Start pulsed while scanning must not disturb or restart the move.
    run_move(vecs[4].board, 1'b0, 3'd3, 3'd3, 3);
    chk("busy_start_flip", 128'(o_flip), 128'd3);
    chk("busy_start_board", o_board, vecs[4].exp_board);
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge i_clk);
      #1;
      saw_done = saw_done | o_done | o_busy;
    end
    chk("busy_start_no_restart", 128'(saw_done), 128'd0);

    // Asynchronous reset in the middle of flipping the long row.
    @(negedge i_clk);
    i_board = line_b; i_color = 1'b1; i_row = 3'd0; i_col = 3'd0; i_start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge i_clk);
      #1;
      if (n == 1) i_start = 1'b0;
    end
    chk("midflip_busy", 128'(o_busy), 128'd1);
    i_rst_n = 1'b0;
    #1;
    chk("abort_board", o_board, EMPTY_B);
    chk("abort_flip", 128'(o_flip), 128'd0);
    chk("abort_done_busy", 128'({o_done, o_busy}), 128'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge i_clk);
      #1;
      saw_done = saw_done | o_done;
    end
    chk("abort_no_done", 128'(saw_done), 128'd0);
    run_move(vecs[0].board, 1'b0, 3'd2, 3'd4, 0);
    chk("post_abort_flip", 128'(o_flip), 128'd1);
    chk("post_abort_board", o_board, vecs[0].exp_board);

`ifdef FLIP_ENGINE_PROBE_EN
    i_probe = 1'b1;
    run_move(vecs[0].board, 1'b0, 3'd2, 3'd4, 0);
    i_probe = 1'b0;
    chk("probe_flip", 128'(o_flip), 128'd1);
    chk("probe_board", o_board, open_b);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
